// File: rtl/paratoserial_lanes.sv
// Multi-lane MSB-first parallel-to-serial converter with a shared bit counter, frame strobe and capture pulse.
// Define PS_SYNC_EN to send SYNC_WORDS idle words after every reset before the first capture.
//
// state | meaning
// SYNC  | idle words only, in_ready held low, load edges counted
// RUN   | in_ready pulses on every load edge, lane words captured
module paratoserial_lanes #(
  parameter int unsigned      LANES      = 2,
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM   = 8'hBC,
  parameter int unsigned      SYNC_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  output logic                   in_ready,
  output logic [LANES-1:0]       out,
  output logic                   frame,
  output logic [LANES-1:0]       active
);

  localparam int unsigned CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q [LANES];
  logic [WIDTH-1:0] sh_d [LANES];
  logic [LANES-1:0] active_q, active_d;
  logic             load;
  logic             run;

  assign load = (cnt_q == CNT_LAST);

`ifdef PS_SYNC_EN
  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int unsigned SW = (SYNC_WORDS > 2) ? $clog2(SYNC_WORDS) : 1;
  // Leaving SYNC on the load edge that starts the last idle word makes the
  // following load edge the first capture.
  localparam logic [SW-1:0] SYNC_LAST = SW'((SYNC_WORDS > 1) ? SYNC_WORDS - 2 : 0);
  localparam logic [0:0] ST_RESET = (SYNC_WORDS > 1) ? ST_SYNC : ST_RUN;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sync_q, sync_d;

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    if (state_q == ST_SYNC && load) begin
      sync_d = sync_q + 1'b1;
      if (sync_q == SYNC_LAST) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  // SYNC_WORDS has no role without the sync phase.
  logic unused_sync_words;
  assign unused_sync_words = ^SYNC_WORDS;
  assign run = 1'b1;
`endif

  assign in_ready = run && load;
  assign frame    = (cnt_q == '0);
  assign active   = active_q;

  always_comb begin
    cnt_d    = load ? '0 : cnt_q + 1'b1;
    active_d = active_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (load) begin
        sh_d[i]     = (in_ready && in_valid[i]) ? in_data[i*WIDTH +: WIDTH] : IDLE_SYM;
        active_d[i] = in_ready && in_valid[i];
      end else begin
        sh_d[i] = {sh_q[i][WIDTH-2:0], 1'b0};
      end
      out[i] = sh_q[i][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= '0;
      for (int i = 0; i < int'(LANES); i++) sh_q[i] <= IDLE_SYM;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      for (int i = 0; i < int'(LANES); i++) sh_q[i] <= sh_d[i];
    end
  end

endmodule
